// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: encodings, FSM and ALU
// enumerations, and immediate/jump-target helpers.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Widest datapath the sign-extension helper serves; callers truncate.
    localparam int MAX_DW = 64;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef enum logic [2:0] {
        IC_R,
        IC_ADDI,
        IC_LW,
        IC_SW,
        IC_BEQ,
        IC_J,
        IC_BAD
    } iclass_e;

    function automatic logic [MAX_DW-1:0] sext16(input logic [15:0] imm);
        return {{(MAX_DW-16){imm[15]}}, imm};
    endfunction

    function automatic logic [27:0] jump_low(input logic [25:0] target);
        return {target, 2'b00};
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// register 0 reads as zero and ignores writes.
module mips_regfile #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int RW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [RW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [RW-1:0] raddr_a_i,
    input  logic [RW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_a_o,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: one ALU and one unified memory port, sequenced by
// a FETCH/DECODE/EXEC/MEM/WB FSM with a req/ready memory handshake.
module mips_multicycle
    import mips_pkg::*;
#(
    parameter int            DW       = 32,
    parameter int            AW       = 32,
    parameter int            NREG     = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          halt,
    output logic [AW-1:0] pc_out
);

    localparam int            RW      = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [AW-1:0] PC_STEP = AW'(4);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   ir_q, ir_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] alu_out_q, alu_out_d;
    logic [DW-1:0] mdr_q, mdr_d;

    logic [5:0]    op;
    logic [5:0]    funct;
    logic [RW-1:0] rs_idx, rt_idx, rd_idx;
    iclass_e       iclass;
    alu_op_e       alu_op;

    logic [DW-1:0] imm_sext;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_res;
    logic [AW-1:0] pc_branch;
    logic [AW-1:0] pc_jump;
    logic [27:0]   jump_lo;

    logic          rf_we;
    logic [RW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata_a, rf_rdata_b;

    assign op     = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign rs_idx = ir_q[21 +: RW];
    assign rt_idx = ir_q[16 +: RW];
    assign rd_idx = ir_q[11 +: RW];

    // Classify the held instruction; everything not listed becomes IC_BAD.
    always_comb begin
        iclass = IC_BAD;
        alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                iclass = IC_R;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: iclass = IC_BAD;
                endcase
            end
            OP_ADDI: iclass = IC_ADDI;
            OP_LW:   iclass = IC_LW;
            OP_SW:   iclass = IC_SW;
            OP_BEQ:  iclass = IC_BEQ;
            OP_J:    iclass = IC_J;
            default: iclass = IC_BAD;
        endcase
    end

    assign imm_sext = DW'(sext16(ir_q[15:0]));
    assign alu_b    = (iclass == IC_R) ? b_q : imm_sext;

    always_comb begin
        alu_res = a_q + alu_b;
        case (alu_op)
            ALU_SUB: alu_res = a_q - alu_b;
            ALU_AND: alu_res = a_q & alu_b;
            ALU_OR:  alu_res = a_q | alu_b;
            ALU_SLT: alu_res = {{(DW-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
            default: alu_res = a_q + alu_b;
        endcase
    end

    // PC already points past the branch when EXEC runs.
    assign pc_branch = pc_q + {imm_sext[AW-3:0], 2'b00};
    assign jump_lo   = jump_low(ir_q[25:0]);

    always_comb begin
        pc_jump = pc_q;
        for (int i = 0; i < ((AW < 28) ? AW : 28); i++) begin
            pc_jump[i] = jump_lo[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        rf_we     = 1'b0;
        case (state_q)
            FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    pc_d    = pc_q + PC_STEP;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d     = rf_rdata_a;
                b_d     = rf_rdata_b;
                state_d = (iclass == IC_BAD) ? HALT : EXEC;
            end
            EXEC: begin
                case (iclass)
                    IC_R, IC_ADDI: begin
                        alu_out_d = alu_res;
                        state_d   = WB;
                    end
                    IC_LW, IC_SW: begin
                        alu_out_d = alu_res;
                        state_d   = MEM;
                    end
                    IC_BEQ: begin
                        if (a_q == b_q) begin
                            pc_d = pc_branch;
                        end
                        state_d = FETCH;
                    end
                    IC_J: begin
                        pc_d    = pc_jump;
                        state_d = FETCH;
                    end
                    default: state_d = HALT;
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    if (iclass == IC_LW) begin
                        mdr_d   = mem_rdata;
                        state_d = WB;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            WB: begin
                rf_we   = 1'b1;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
        end
    end

    assign rf_waddr = (iclass == IC_R) ? rd_idx : rt_idx;
    assign rf_wdata = (iclass == IC_LW) ? mdr_q : alu_out_q;

    mips_regfile #(
        .DW   (DW),
        .NREG (NREG),
        .RW   (RW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (rs_idx),
        .raddr_b_i (rt_idx),
        .rdata_a_o (rf_rdata_a),
        .rdata_b_o (rf_rdata_b)
    );

    // Address/data come straight from held registers, so they stay put while stalled.
    assign mem_req   = !rst && ((state_q == FETCH) || (state_q == MEM));
    assign mem_we    = !rst && (state_q == MEM) && (iclass == IC_SW);
    assign mem_addr  = (state_q == MEM) ? alu_out_q[AW-1:0] : pc_q;
    assign mem_wdata = b_q;
    assign halt      = !rst && (state_q == HALT);
    assign pc_out    = rst ? RESET_PC : pc_q;

endmodule

// File: doc/mips_multicycle.md
Name: mips_multicycle

Overview:
Parametrised multicycle successor to the single-cycle MIPS datapath. One shared ALU and one unified instruction/data memory port are sequenced by an FSM, so each instruction takes 3–5 cycles instead of one. The memory port uses a req/ready handshake, so slow or shared memory can stall the core. Supported ISA: add, sub, and, or, slt, addi, lw, sw, beq, j. Unsupported opcodes halt the core.

Parameters:
DW, 32, data/register width; ALU arithmetic is mod 2^DW.
AW, 32, byte-address width of PC and memory port (AW <= DW).
NREG, 32, register count, power of 2 and <= 32; rs/rt/rd use the low clog2(NREG) bits.
RESET_PC, 0, PC loaded on reset (word aligned).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
mem_req  out  1  memory access request
mem_we  out  1  1 = write (sw), 0 = read
mem_addr  out  AW  byte address (fetch: PC; data: ALU result)
mem_wdata  out  DW  store data (rt)
mem_rdata  in  DW  read data, valid in the cycle mem_ready=1
mem_ready  in  1  access completes this cycle
halt  out  1  core stopped on an unsupported opcode
pc_out  out  AW  current PC

Behaviour:
- Reset (sync, active-high): at the edge with rst=1: state<=FETCH, PC<=RESET_PC, all registers<=0, halt<=0. While rst=1: mem_req=0, mem_we=0, halt=0, pc_out=RESET_PC. rst mid-access abandons the access; no register or PC update occurs.
- Handshake: mem_req=!rst && state in {FETCH, MEM}. mem_addr, mem_we and mem_wdata stay stable while mem_req=1 && mem_ready=0. A transfer completes at the edge where mem_req && mem_ready. mem_ready is ignored while mem_req=0. Each wait cycle adds one cycle of latency.
- Encoding: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0], target[25:0]. Opcodes: R=0x00 (funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A), addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- FSM:
  - FETCH: on ready, IR<=mem_rdata, PC<=PC+4 → DECODE.
  - DECODE: A<=R[rs], B<=R[rt]. Unsupported op or funct → HALT; else → EXEC.
  - EXEC:
    - R/addi: ALUOut<=result → WB.
    - lw/sw: ALUOut<=A+sext(imm) → MEM.
    - beq: if A==B, PC<=PC+(sext(imm)<<2) → FETCH.
    - j: PC<={PC[AW-1:28], target, 2'b00} → FETCH.
  - MEM: lw: on ready, MDR<=mem_rdata → WB. sw: on ready → FETCH.
  - WB: R: R[rd]<=ALUOut. addi: R[rt]<=ALUOut. lw: R[rt]<=MDR. Then → FETCH.
  - HALT: halt=1, mem_req=0, PC frozen. Leaves only on rst.
- Cycle counts with mem_ready tied high: beq/j 3; R/addi/sw 4; lw 5.
- Register 0 always reads 0; writes to it are discarded. Register reads return the value written in an earlier cycle.
- Arithmetic: add/sub/addi wrap mod 2^DW with no overflow trap. slt is signed and gives 1 or 0, zero-extended. sext extends imm to DW. Address is the low AW bits of ALUOut; the low 2 bits are passed through unchecked.
- PC wraps mod 2^AW.

Decomposition:
- Package mips_pkg: opcode and funct localparams, FSM state enum (FETCH, DECODE, EXEC, MEM, WB, HALT), ALU-op enum, and sext/jump-target helper functions.
- One sub-module, mips_regfile: NREG×DW, 2 async read ports, 1 sync write port, r0 hardwired to 0.
- ALU stays inline.

Test Plan:
1. Reset/fetch: rst high 2 cycles, then low, RESET_PC=0, mem_ready=1 → first cycle after release: mem_req=1, mem_we=0, mem_addr=0; pc_out=4 after that edge.
2. ALU + store: program 0x20010005, 0x20020007, 0x00221820, 0xAC030040 → write seen at mem_addr=0x40 with mem_wdata=12 (0xC), 16 cycles after reset release.
3. Load/slt/r0: mem[0x40]=0xFFFFFFFF; lw $4,0x40($0) (0x8C040040); slt $5,$4,$0 (0x0080282A); add $0,$5,$5 (0x00A50020); sw $5 and $0 → stores 1 and 0; lw takes exactly 5 cycles.
4. Handshake stall: mem_ready held low 3 cycles during each fetch → mem_addr/mem_req stable throughout; each instruction's latency grows by exactly 3; results are identical to test 2.
5. Branch/jump: beq $1,$1,-1 (0x1021FFFF) at 0x10 → next fetch address is 0x10 (self-loop). j 0x40 (0x08000010) → next fetch at 0x40.
6. Halt and reset: fetch 0xFC000000 → halt=1 two cycles later, mem_req stays 0, pc_out frozen. Then assert rst for 1 cycle during an lw MEM wait → halt=0, next fetch at RESET_PC, target register unchanged.
